// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder. It also sequences multi-cycle
// (mult/div class) operations with a down-counter and one step pulse per cycle.
`timescale 1ns/1ps

module alu_ctrl_seq #(
    parameter int          FUNC_W    = 6,
    parameter logic [2:0]  MC_HI     = 3'b011,
    parameter int          MC_CYCLES = 8,
    localparam int         CNT_W     = $clog2(MC_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_alu_op,
    input  logic [FUNC_W-1:0] i_funct,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [3:0]        o_alu_ctrl,
    output logic              o_mc_busy,
    output logic              o_mc_step,
    output logic [CNT_W-1:0]  o_mc_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_MC   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_alu_ctrl;
    logic [CNT_W-1:0]   r_mc_count;
    logic [2:0]         w_base;
    logic               w_is_mc;
    logic               w_accept;

    if (MC_CYCLES < 1) begin : g_bad_cycles
        $error("alu_ctrl_seq: MC_CYCLES must be at least 1");
    end

    // Narrow funct fields cannot encode the multi-cycle marker at all.
    if (FUNC_W >= 6) begin : g_mc_decode
        assign w_is_mc = (i_alu_op[2:1] == 2'b01) && (i_funct[5:3] == MC_HI);
    end else begin : g_no_mc_decode
        assign w_is_mc = 1'b0;
    end

    always_comb begin
        w_base = 3'b000;
        casez (i_alu_op)
            3'b000: w_base = 3'b000;
            3'b001: w_base = 3'b010;
            3'b01?: begin
                case (i_funct[2:0])
                    3'b000:  w_base = 3'b110;
                    3'b001:  w_base = 3'b000;
                    3'b010:  w_base = 3'b010;
                    3'b011:  w_base = 3'b001;
                    3'b100:  w_base = 3'b101;
                    3'b101:  w_base = 3'b111;
                    3'b110:  w_base = 3'b101;
                    default: w_base = 3'b111;
                endcase
            end
            default: w_base = i_alu_op;
        endcase
    end

    // flush overrides every transition, including an accept in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        if (i_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = w_is_mc ? ST_MC : ST_OUT;
                    end
                end
                ST_MC: begin
                    if (r_mc_count == '0) begin
                        w_next_state = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_alu_ctrl <= 4'b0000;
            r_mc_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_flush) begin
                r_mc_count <= '0;
            end else if (w_accept) begin
                r_alu_ctrl <= {w_is_mc, w_base};
                r_mc_count <= w_is_mc ? MC_LOAD : '0;
            end else if ((r_state == ST_MC) && (r_mc_count != '0)) begin
                r_mc_count <= r_mc_count - CNT_W'(1);
            end
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_OUT);
    assign o_mc_busy   = (r_state == ST_MC);
    assign o_mc_step   = (r_state == ST_MC);
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_mc_count  = r_mc_count;

endmodule
